// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared constants for the CPU-bus memory responder: I/O page register
//   offsets, STATUS and CTRL bit positions, and the default I/O page base.
package mem_responder_pkg;

    localparam logic [15:0] DEF_IO_BASE = 16'hFF00;

    // I/O page register offsets (address[2:0])
    localparam logic [2:0] OFS_TXDATA = 3'd0;
    localparam logic [2:0] OFS_STATUS = 3'd1;
    localparam logic [2:0] OFS_RXDATA = 3'd2;
    localparam logic [2:0] OFS_TMR_LO = 3'd3;
    localparam logic [2:0] OFS_TMR_HI = 3'd4;
    localparam logic [2:0] OFS_CTRL   = 3'd5;

    // STATUS bit positions
    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_VALID = 2;
    localparam int unsigned ST_TMR_WRAP = 3;
    localparam int unsigned ST_TX_OVF   = 4;
    localparam int unsigned ST_RX_OVR   = 5;

    // CTRL bit positions
    localparam int unsigned CTRL_CLR_WRAP = 0;
    localparam int unsigned CTRL_FLUSH    = 1;
    localparam int unsigned CTRL_CLR_ERR  = 2;

endpackage

// File: rtl/mem_resp_fifo.sv
// mem_resp_fifo
//   Byte FIFO, depth 2**AW, used as the TX queue of mem_responder.
//   Pointers carry one extra bit to tell full from empty.
// Ports:
//   clk, rst (async, active-low)
//   push, wdata  : enqueue request (accepted if not full, or if popping)
//   pop          : dequeue request (ignored when empty)
//   flush        : reset pointers; wins over push/pop in the same cycle
//   rdata        : head byte, 0 when empty
//   full, empty  : occupancy flags
module mem_resp_fifo #(
    parameter int unsigned AW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    logic [7:0]  mem [2**AW];
    logic [AW:0] wp, rp;
    logic        do_pop, do_push;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   CPU-bus responder: on-chip byte RAM at 0x0000..2**RAM_AW-1 plus an
//   8-byte I/O page at IO_BASE (TX FIFO, STATUS, RX holding register,
//   timer, CTRL). Bus inputs are sampled on posedge; din is registered there
//   so it is valid at the CPU's next negedge.
// Ports:
//   clk, rst (async, active-low)
//   read, address, dout : CPU bus inputs (read=0 -> write cycle)
//   din                 : registered read data to CPU
//   tx_data, tx_valid, tx_ready : TX FIFO drain (pop on valid & ready)
//   rx_data, rx_strobe  : incoming byte and its one-cycle valid pulse
// Configuration:
//   MEM_RESPONDER_TIMER_EN : builds the 16-bit timer, hi latch and tmr_wrap.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned RAM_AW  = 12,
    parameter logic [15:0] IO_BASE = DEF_IO_BASE,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic [15:0] address,
    input  logic [7:0]  dout,
    output logic [7:0]  din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_strobe
);

    logic       ram_sel, io_sel;
    logic [2:0] ofs;
    logic [7:0] ram [2**RAM_AW];
    logic [7:0] ram_rd, rdata, status;
    logic       tx_push, tx_pop, tx_full, tx_empty, ctrl_wr, rx_rd;
    logic       tx_ovf, rx_valid, rx_ovr, tmr_wrap;
    logic [7:0] rx_q;

    assign ram_sel = (address[15:RAM_AW] == '0);
    assign io_sel  = (address[15:3] == IO_BASE[15:3]);
    assign ofs     = address[2:0];

    assign tx_push = io_sel && !read && (ofs == OFS_TXDATA);
    assign ctrl_wr = io_sel && !read && (ofs == OFS_CTRL);
    assign rx_rd   = io_sel &&  read && (ofs == OFS_RXDATA);
    assign tx_pop  = tx_valid && tx_ready;
    assign tx_valid = !tx_empty;

    mem_resp_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (ctrl_wr && dout[CTRL_FLUSH]),
        .wdata (dout),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // RAM: contents not reset; the comb read sees pre-write data, so a
    // read-during-write returns the old byte.
    assign ram_rd = ram[address[RAM_AW-1:0]];

    always_ff @(posedge clk) begin
        if (ram_sel && !read) ram[address[RAM_AW-1:0]] <= dout;
    end

`ifdef MEM_RESPONDER_TIMER_EN
    logic [15:0] timer;
    logic [7:0]  tmr_hi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer    <= '0;
            tmr_hi   <= '0;
            tmr_wrap <= 1'b0;
        end else begin
            timer <= timer + 16'd1;
            if (timer == 16'hFFFF)
                tmr_wrap <= 1'b1;
            else if (ctrl_wr && dout[CTRL_CLR_WRAP])
                tmr_wrap <= 1'b0;
            if (io_sel && read && (ofs == OFS_TMR_LO))
                tmr_hi <= timer[15:8];
        end
    end
`else
    assign tmr_wrap = 1'b0;
`endif

    always_comb begin
        status = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_VALID] = rx_valid;
        status[ST_TMR_WRAP] = tmr_wrap;
        status[ST_TX_OVF]   = tx_ovf;
        status[ST_RX_OVR]   = rx_ovr;
    end

    always_comb begin
        rdata = '0;
        if (ram_sel) begin
            rdata = ram_rd;
        end else if (io_sel) begin
            case (ofs)
                OFS_STATUS: rdata = status;
                OFS_RXDATA: rdata = rx_q;
`ifdef MEM_RESPONDER_TIMER_EN
                OFS_TMR_LO: rdata = timer[7:0];
                OFS_TMR_HI: rdata = tmr_hi;
`endif
                default:    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din      <= '0;
            rx_q     <= '0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            tx_ovf   <= 1'b0;
        end else begin
            din <= rdata;

            // A strobe coinciding with an RXDATA read reloads the register
            // and keeps rx_valid set; the read already got the old byte.
            if (rx_strobe) begin
                rx_q     <= rx_data;
                rx_valid <= 1'b1;
            end else if (rx_rd) begin
                rx_valid <= 1'b0;
            end

            if (rx_strobe && rx_valid && !rx_rd)
                rx_ovr <= 1'b1;
            else if (ctrl_wr && dout[CTRL_CLR_ERR])
                rx_ovr <= 1'b0;

            if (tx_push && tx_full && !tx_pop)
                tx_ovf <= 1'b1;
            else if (ctrl_wr && dout[CTRL_CLR_ERR])
                tx_ovf <= 1'b0;
        end
    end

endmodule
